// File: rtl/osc_gen.sv
`default_nettype none
// ============================================================================
// Module   : osc_gen
// Brief    : Emulator oscillator; square wave on clk_o with programmable low
//            and high durations in emulated time, requesting timesteps that
//            land exactly on its next edge. Optional rising-edge counter is
//            enabled by defining OSC_GEN_CYCLE_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module osc_gen #(
    parameter int                  DT_WIDTH  = 27,
    parameter logic [DT_WIDTH-1:0] DT_MAX    = {DT_WIDTH{1'b1}},
    parameter int                  CNT_WIDTH = 32
) (
    input  logic                 emu_clk,
    input  logic                 emu_rst_n,
    input  logic                 en_i,
    input  logic [DT_WIDTH-1:0]  t_lo_i,
    input  logic [DT_WIDTH-1:0]  t_hi_i,
    input  logic [DT_WIDTH-1:0]  emu_dt_i,
    output logic [DT_WIDTH-1:0]  dt_req_o,
    output logic                 clk_o,
    output logic                 edge_o,
    output logic                 err_o,
    output logic [CNT_WIDTH-1:0] cycle_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2
    } state_t;

    localparam logic [DT_WIDTH-1:0] c_DT_ONE = {{(DT_WIDTH-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DT_WIDTH-1:0] r_t_rem;
    logic [DT_WIDTH-1:0] w_t_rem_nxt;
    logic [DT_WIDTH-1:0] w_t_lo;
    logic [DT_WIDTH-1:0] w_t_hi;
    logic                r_clk;
    logic                w_clk_nxt;
    logic                r_edge;
    logic                w_edge_nxt;
    logic                r_err;
    logic                w_err_nxt;

    // A zero duration would stall emulated time, so it is clamped to one unit.
    assign w_t_lo = (t_lo_i == '0) ? c_DT_ONE : t_lo_i;
    assign w_t_hi = (t_hi_i == '0) ? c_DT_ONE : t_hi_i;

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            r_state <= S_IDLE;
            r_t_rem <= '0;
            r_clk   <= 1'b0;
            r_edge  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_t_rem <= w_t_rem_nxt;
            r_clk   <= w_clk_nxt;
            r_edge  <= w_edge_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_t_rem_nxt = r_t_rem;
        w_clk_nxt   = r_clk;
        w_edge_nxt  = 1'b0;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (en_i) begin
                    w_state_nxt = S_LO;
                    w_t_rem_nxt = w_t_lo;
                end
            end
            S_LO, S_HI: begin
                if (!en_i) begin
                    // Disable beats a coinciding edge; only a high output produces a pulse.
                    w_state_nxt = S_IDLE;
                    w_t_rem_nxt = '0;
                    w_clk_nxt   = 1'b0;
                    w_edge_nxt  = r_clk;
                end else if (emu_dt_i < r_t_rem) begin
                    w_t_rem_nxt = r_t_rem - emu_dt_i;
                end else begin
                    // Any overshoot is dropped: the new phase starts at the edge itself.
                    w_clk_nxt   = ~r_clk;
                    w_edge_nxt  = 1'b1;
                    if (emu_dt_i != r_t_rem) begin
                        w_err_nxt = 1'b1;
                    end
                    if (r_state == S_LO) begin
                        w_state_nxt = S_HI;
                        w_t_rem_nxt = w_t_hi;
                    end else begin
                        w_state_nxt = S_LO;
                        w_t_rem_nxt = w_t_lo;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_t_rem_nxt = '0;
                w_clk_nxt   = 1'b0;
            end
        endcase
    end

    assign dt_req_o = ((r_state == S_LO) || (r_state == S_HI)) ? r_t_rem : DT_MAX;
    assign clk_o    = r_clk;
    assign edge_o   = r_edge;
    assign err_o    = r_err;

`ifdef OSC_GEN_CYCLE_CNT_EN
    logic                 w_rise;
    logic [CNT_WIDTH-1:0] r_cnt;

    assign w_rise = (r_state == S_LO) && (w_state_nxt == S_HI);

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            r_cnt <= '0;
        end else if (w_rise && (r_cnt != {CNT_WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign cycle_cnt_o = r_cnt;
`else
    assign cycle_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_osc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_osc_gen
// Brief    : Self-checking bench for osc_gen: vector table, directed reset
//            sequences and randomized run against an absolute-time model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_osc_gen;

    localparam int             DT_WIDTH  = 27;
    localparam int             CNT_WIDTH = 32;
    localparam logic [26:0]    DT_MAX    = '1;
`ifdef OSC_GEN_CYCLE_CNT_EN
    localparam bit             FEAT      = 1'b1;
`else
    localparam bit             FEAT      = 1'b0;
`endif

    logic                 emu_clk = 1'b0;
    logic                 emu_rst_n;
    logic                 en_i;
    logic [DT_WIDTH-1:0]  t_lo_i;
    logic [DT_WIDTH-1:0]  t_hi_i;
    logic [DT_WIDTH-1:0]  emu_dt_i;
    logic [DT_WIDTH-1:0]  dt_req_o;
    logic                 clk_o;
    logic                 edge_o;
    logic                 err_o;
    logic [CNT_WIDTH-1:0] cycle_cnt_o;

    always #5 emu_clk = ~emu_clk;

    osc_gen dut (
        .emu_clk     (emu_clk),
        .emu_rst_n   (emu_rst_n),
        .en_i        (en_i),
        .t_lo_i      (t_lo_i),
        .t_hi_i      (t_hi_i),
        .emu_dt_i    (emu_dt_i),
        .dt_req_o    (dt_req_o),
        .clk_o       (clk_o),
        .edge_o      (edge_o),
        .err_o       (err_o),
        .cycle_cnt_o (cycle_cnt_o)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model in absolute emulated time: the next edge is a time stamp, not a countdown.
    int     m_phase;   // 0 idle, 1 low, 2 high
    longint m_now;
    longint m_edge;
    bit     m_clk;
    bit     m_pulse;
    bit     m_err;
    longint m_cnt;

    function automatic longint dur(input longint t);
        return (t == 0) ? 64'd1 : t;
    endfunction

    function automatic longint m_req();
        return (m_phase == 0) ? longint'(DT_MAX) : (m_edge - m_now);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_now = 0; m_edge = 0;
        m_clk = 0; m_pulse = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit en, input longint tlo, input longint thi, input longint d);
        m_pulse = 0;
        if (m_phase == 0) begin
            if (en) begin
                m_phase = 1;
                m_edge  = m_now + dur(tlo);
            end
        end else if (!en) begin
            m_pulse = m_clk;
            m_clk   = 0;
            m_phase = 0;
        end else if (d < m_edge - m_now) begin
            m_now += d;
        end else begin
            if (d > m_edge - m_now) m_err = 1;
            m_now   = m_edge;
            m_clk   = !m_clk;
            m_pulse = 1;
            if (m_phase == 1) begin
                m_phase = 2;
                m_cnt++;
                m_edge = m_now + dur(thi);
            end else begin
                m_phase = 1;
                m_edge = m_now + dur(tlo);
            end
        end
    endtask

    task automatic cycle(input bit en, input longint tlo, input longint thi, input longint d);
        en_i     = en;
        t_lo_i   = DT_WIDTH'(tlo);
        t_hi_i   = DT_WIDTH'(thi);
        emu_dt_i = DT_WIDTH'(d);
        @(posedge emu_clk);
        #1;
        model_step(en, tlo, thi, d);
    endtask

    task automatic check_model(input string tag);
        chk({tag, " dt_req"}, longint'(dt_req_o), m_req());
        chk({tag, " clk"},    longint'(clk_o),    longint'(m_clk));
        chk({tag, " edge"},   longint'(edge_o),   longint'(m_pulse));
        chk({tag, " err"},    longint'(err_o),    longint'(m_err));
        chk({tag, " cnt"},    longint'(cycle_cnt_o), FEAT ? m_cnt : 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " dt_req"}, longint'(dt_req_o), longint'(DT_MAX));
        chk({tag, " clk"},    longint'(clk_o), 0);
        chk({tag, " edge"},   longint'(edge_o), 0);
        chk({tag, " err"},    longint'(err_o), 0);
        chk({tag, " cnt"},    longint'(cycle_cnt_o), 0);
    endtask

    typedef struct {
        bit     en;
        longint tlo;
        longint thi;
        longint dt;
        longint req;
        bit     clk;
        bit     edg;
        bit     err;
        longint cnt;
    } vec_t;

    function automatic vec_t mk(input bit en, input longint tlo, input longint thi, input longint dt,
                                input longint req, input bit clk, input bit edg, input bit err,
                                input longint cnt);
        vec_t v;
        v.en = en; v.tlo = tlo; v.thi = thi; v.dt = dt;
        v.req = req; v.clk = clk; v.edg = edg; v.err = err; v.cnt = cnt;
        return v;
    endfunction

    vec_t vecs[19];

    initial begin
        // Exact-grant toggling, 7-unit stepping, overshoot, mid-phase duration change, disable.
        vecs[0]  = mk(1, 30, 20,  0, 30, 0, 0, 0, 0);
        vecs[1]  = mk(1, 30, 20, 30, 20, 1, 1, 0, 1);
        vecs[2]  = mk(1, 30, 20, 20, 30, 0, 1, 0, 1);
        vecs[3]  = mk(1, 30, 20,  7, 23, 0, 0, 0, 1);
        vecs[4]  = mk(1, 30, 20,  7, 16, 0, 0, 0, 1);
        vecs[5]  = mk(1, 30, 20,  7,  9, 0, 0, 0, 1);
        vecs[6]  = mk(1, 30, 20,  7,  2, 0, 0, 0, 1);
        vecs[7]  = mk(1, 30, 20,  2, 20, 1, 1, 0, 2);
        vecs[8]  = mk(1, 30, 20, 20, 30, 0, 1, 0, 2);
        vecs[9]  = mk(1, 30, 20, 20, 10, 0, 0, 0, 2);
        vecs[10] = mk(1, 30, 20, 15, 20, 1, 1, 1, 3);
        vecs[11] = mk(1, 30, 20,  0, 20, 1, 0, 1, 3);
        vecs[12] = mk(1, 30, 40,  5, 15, 1, 0, 1, 3);
        vecs[13] = mk(1,  0, 40, 15,  1, 0, 1, 1, 3);
        vecs[14] = mk(1,  0, 40,  1, 40, 1, 1, 1, 4);
        vecs[15] = mk(1,  0, 40, 40,  1, 0, 1, 1, 4);
        vecs[16] = mk(1, 30, 20,  1, 20, 1, 1, 1, 5);
        vecs[17] = mk(0, 30, 20, 20, longint'(DT_MAX), 0, 1, 1, 5);
        vecs[18] = mk(0, 30, 20,  5, longint'(DT_MAX), 0, 0, 1, 5);

        emu_rst_n = 1'b0;
        en_i = 1'b0; t_lo_i = '0; t_hi_i = '0; emu_dt_i = DT_WIDTH'(5);
        model_reset();
        #3;
        check_reset_vals("in_reset");
        #9 emu_rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cycle(0, 30, 20, 5);
            check_model($sformatf("idle%0d", i));
        end

        for (int i = 0; i < 19; i++) begin
            cycle(vecs[i].en, vecs[i].tlo, vecs[i].thi, vecs[i].dt);
            chk($sformatf("v%0d dt_req", i), longint'(dt_req_o), vecs[i].req);
            chk($sformatf("v%0d clk", i),    longint'(clk_o),    longint'(vecs[i].clk));
            chk($sformatf("v%0d edge", i),   longint'(edge_o),   longint'(vecs[i].edg));
            chk($sformatf("v%0d err", i),    longint'(err_o),    longint'(vecs[i].err));
            chk($sformatf("v%0d cnt", i),    longint'(cycle_cnt_o), FEAT ? vecs[i].cnt : 64'd0);
        end

        // Disable while high coinciding with an edge-completing grant.
        emu_rst_n = 1'b0;
        #2 emu_rst_n = 1'b1;
        model_reset();
        cycle(1, 30, 20, 0);
        cycle(1, 30, 20, 30);
        check_model("pre_dis");
        cycle(0, 30, 20, 20);
        check_model("dis_hi");
        chk("dis_hi clk", longint'(clk_o), 0);
        chk("dis_hi edge", longint'(edge_o), 1);

        model_reset();
        emu_rst_n = 1'b0;
        #2 emu_rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            longint tlo, thi, d, req;
            int r;
            tlo = longint'($urandom_range(0, 40));
            thi = longint'($urandom_range(0, 40));
            req = m_req();
            r   = int'($urandom_range(0, 9));
            if (m_phase == 0)  d = longint'($urandom_range(0, 50));
            else if (r < 4)    d = req;
            else if (r < 8)    d = longint'($urandom_range(0, 25)) < req ? longint'($urandom_range(0, 25)) % req : req;
            else if (r == 8)   d = req + longint'($urandom_range(1, 5));
            else               d = 0;
            cycle($urandom_range(0, 19) != 0, tlo, thi, d);
            check_model($sformatf("rnd%0d", i));
        end

        // Force an overshoot, then reach the high phase and reset asynchronously.
        begin
            int budget;
            budget = 0;
            while (m_phase == 0 && budget < 20) begin
                cycle(1, 10, 10, 0);
                budget++;
            end
            cycle(1, 10, 10, m_req() + 3);
            check_model("ovs");
            while (m_phase != 2 && budget < 40) begin
                cycle(1, 10, 10, m_req());
                budget++;
            end
            chk("reach_hi budget", longint'(m_phase == 2), 1);
            cycle(1, 10, 10, 4);
            check_model("pre_arst");
            chk("pre_arst err", longint'(err_o), 1);
            chk("pre_arst clk", longint'(clk_o), 1);
            #2 emu_rst_n = 1'b0;
            #1;
            check_reset_vals("arst_mid");
            #3 emu_rst_n = 1'b1;
            model_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
